// File: rtl/iomem_gpio_bank_pkg.sv
// Shared definitions for the iomem GPIO bank: register offsets, pin limit
// and the byte-strobe expansion helper.
package iomem_gpio_bank_pkg;

  // Word offsets decoded from iomem_addr[4:2].
  typedef enum logic [2:0] {
    GPIO_OFS_OUT     = 3'd0,
    GPIO_OFS_DIR     = 3'd1,
    GPIO_OFS_IN      = 3'd2,
    GPIO_OFS_RISE_EN = 3'd3,
    GPIO_OFS_FALL_EN = 3'd4,
    GPIO_OFS_STATUS  = 3'd5,
    GPIO_OFS_SET     = 3'd6,
    GPIO_OFS_CLR     = 3'd7
  } gpio_reg_e;

  localparam int GPIO_MIN_PINS = 1;
  localparam int GPIO_MAX_PINS = 32;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{wstrb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/iomem_gpio_bank_in_sync.sv
// Pad input synchroniser for the GPIO bank. Brings pin_di into the clk
// domain, keeps a one-cycle-delayed copy and reports rising/falling edges.
// Edges are masked until the chain and the delayed copy hold real samples,
// so pins that are already high when reset is released do not look like rises.
module iomem_gpio_bank_in_sync #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_PINS-1:0] pin_di,
  output logic [NUM_PINS-1:0] pin_sync,
  output logic [NUM_PINS-1:0] rise,
  output logic [NUM_PINS-1:0] fall
);

  // The counter saturates here; SYNC_STAGES is at most 4, so 3 bits suffice.
  localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] chain_q;
  logic [NUM_PINS-1:0]                  prev_q;
  logic [2:0]                           arm_cnt_q;
  logic                                 armed;

  // Synchroniser chain, delayed copy and post-reset arming counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain_q   <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin_di};
      prev_q  <= chain_q[SYNC_STAGES-1];
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + 3'd1;
      end
    end
  end

  assign armed    = (arm_cnt_q == ARM_COUNT);
  assign pin_sync = chain_q[SYNC_STAGES-1];
  assign rise     = armed ? (pin_sync & ~prev_q) : '0;
  assign fall     = armed ? (~pin_sync & prev_q) : '0;

endmodule

// File: rtl/iomem_gpio_bank.sv
// GPIO bank on the picosoc iomem bus: output data, direction, synchronised
// input read-back, atomic set/clear and sticky edge flags with a level irq.
// Pad cells live in the board top; this block only drives their D/OE nets.
module iomem_gpio_bank #(
  parameter int         NUM_PINS    = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h09,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_PINS-1:0] pin_di,
  output logic [NUM_PINS-1:0] pin_do,
  output logic [NUM_PINS-1:0] pin_oe,
  output logic                irq
);

  import iomem_gpio_bank_pkg::*;

  if (NUM_PINS < GPIO_MIN_PINS || NUM_PINS > GPIO_MAX_PINS) begin : g_bad_num_pins
    $error("iomem_gpio_bank: NUM_PINS must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("iomem_gpio_bank: SYNC_STAGES must be in 2..4");
  end

  typedef logic [NUM_PINS-1:0] pins_t;

  logic        decode;
  logic        wr_en;
  gpio_reg_e   ofs;
  logic [31:0] byte_mask;
  logic [31:0] rd_mux;
  pins_t       wmask;
  pins_t       wbits;
  pins_t       out_q, dir_q, rise_en_q, fall_en_q, status_q;
  pins_t       out_d, status_clr;
  pins_t       pin_sync, rise, fall, edge_set;
  logic        unused_bits;

  // A request is taken only while no acknowledge is outstanding, which makes
  // a held request complete every other cycle.
  assign decode    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign wr_en     = decode && (iomem_wstrb != 4'b0000);
  assign ofs       = gpio_reg_e'(iomem_addr[4:2]);
  assign byte_mask = strobe_mask(iomem_wstrb);
  assign wmask     = byte_mask[NUM_PINS-1:0];
  assign wbits     = iomem_wdata[NUM_PINS-1:0] & wmask;

  // Address bits outside the decode and data bits above NUM_PINS are ignored.
  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, byte_mask};

  iomem_gpio_bank_in_sync #(
    .NUM_PINS   (NUM_PINS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_in_sync (
    .clk     (clk),
    .resetn  (resetn),
    .pin_di  (pin_di),
    .pin_sync(pin_sync),
    .rise    (rise),
    .fall    (fall)
  );

  // Enables are the registered (pre-edge) values, so an enable written on
  // the same edge as a detected edge still uses its old setting.
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);

  // Next OUT value from OUT/SET/CLR writes and the W1C mask for STATUS.
  // NOTE: every variable gets a default before the case so no latch is inferred
  // on the paths that do not assign it.
  always_comb begin
    out_d      = out_q;
    status_clr = '0;
    if (wr_en) begin
      case (ofs)
        GPIO_OFS_OUT:    out_d      = (out_q & ~wmask) | wbits;
        GPIO_OFS_SET:    out_d      = out_q | wbits;
        GPIO_OFS_CLR:    out_d      = out_q & ~wbits;
        GPIO_OFS_STATUS: status_clr = wbits;
        default:         ;
      endcase
    end
  end

  // Read-back mux; bits at and above NUM_PINS read as zero.
  always_comb begin
    rd_mux = '0;
    case (ofs)
      GPIO_OFS_OUT:     rd_mux = 32'(out_q);
      GPIO_OFS_DIR:     rd_mux = 32'(dir_q);
      GPIO_OFS_IN:      rd_mux = 32'(pin_sync);
      GPIO_OFS_RISE_EN: rd_mux = 32'(rise_en_q);
      GPIO_OFS_FALL_EN: rd_mux = 32'(fall_en_q);
      GPIO_OFS_STATUS:  rd_mux = 32'(status_q);
      default:          rd_mux = '0;
    endcase
  end

  // Control/status registers; a new edge beats a W1C of the same bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      out_q    <= out_d;
      status_q <= (status_q & ~status_clr) | edge_set;
      if (wr_en && ofs == GPIO_OFS_DIR) begin
        dir_q <= (dir_q & ~wmask) | wbits;
      end
      if (wr_en && ofs == GPIO_OFS_RISE_EN) begin
        rise_en_q <= (rise_en_q & ~wmask) | wbits;
      end
      if (wr_en && ofs == GPIO_OFS_FALL_EN) begin
        fall_en_q <= (fall_en_q & ~wmask) | wbits;
      end
    end
  end

  // One-cycle acknowledge with read data captured on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= decode;
      iomem_rdata <= decode ? rd_mux : '0;
    end
  end

  assign pin_do = out_q;
  assign pin_oe = dir_q;
  assign irq    = |status_q;

endmodule
